cfg_bus_arb: RTL and testbench

CFG_BUS_ARB -- requirements
Module: cfg_bus_arb

---
 rtl/cfg_bus_arb.sv | 194 +++++++++++++++++++
 tb/tb_cfg_bus_arb.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_bus_arb.sv
// Two-requester round-robin arbiter onto a single downstream config bus.
// Define CFG_BUS_ARB_TIMEOUT_EN to abort stalled transactions after TIMEOUT_CYCLES.
module cfg_bus_arb #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m0_wdata,
   input  logic [31:0] m1_wdata,
   input  logic        m0_wr,
   input  logic        m1_wr,
   input  logic        m0_rd,
   input  logic        m1_rd,
   output logic        m0_ack,
   output logic        m1_ack,
   output logic [31:0] m0_rdata,
   output logic [31:0] m1_rdata,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic        s_wr,
   output logic        s_rd,
   input  logic        s_ack,
   input  logic [31:0] s_rdata,
   output logic        grant_id,
   output logic        busy,
   output logic        err_timeout
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

   state_t      state_q, state_d;
   logic        rr_q, rr_d;
   logic        grant_q, grant_d;
   logic        op_wr_q, op_wr_d;
   logic [31:0] s_addr_q, s_addr_d;
   logic [31:0] s_wdata_q, s_wdata_d;
   logic        s_wr_q, s_wr_d;
   logic        s_rd_q, s_rd_d;
   logic        m0_ack_q, m0_ack_d;
   logic        m1_ack_q, m1_ack_d;
   logic [31:0] m0_rdata_q, m0_rdata_d;
   logic [31:0] m1_rdata_q, m1_rdata_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;

   logic        req0, req1;
   logic        pick;
   logic        done;
   logic [31:0] cpl_data;
   logic        to_hit;

   assign req0 = m0_wr | m0_rd;
   assign req1 = m1_wr | m1_rd;

`ifdef CFG_BUS_ARB_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] cnt_q, cnt_d;

   assign to_hit = (cnt_q == TO_LAST);

   // Counter is zero on the first ISSUE cycle and advances once per ISSUE/WAIT cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE) begin
         cnt_d = '0;
      end else if (state_q == ISSUE || state_q == WAIT) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   logic unused_cfg;
   assign to_hit     = 1'b0;
   assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      grant_d    = grant_q;
      op_wr_d    = op_wr_q;
      s_addr_d   = s_addr_q;
      s_wdata_d  = s_wdata_q;
      s_wr_d     = s_wr_q;
      s_rd_d     = s_rd_q;
      m0_rdata_d = m0_rdata_q;
      m1_rdata_d = m1_rdata_q;
      m0_ack_d   = 1'b0;
      m1_ack_d   = 1'b0;
      err_d      = 1'b0;
      pick       = 1'b0;
      done       = 1'b0;
      cpl_data   = '0;

      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               // Contention goes to the pointer; a lone requester wins outright.
               pick      = (req0 && req1) ? rr_q : req1;
               grant_d   = pick;
               s_addr_d  = pick ? m1_addr  : m0_addr;
               s_wdata_d = pick ? m1_wdata : m0_wdata;
               op_wr_d   = pick ? m1_wr    : m0_wr;
               s_wr_d    = op_wr_d;
               s_rd_d    = ~op_wr_d;
               state_d   = ISSUE;
            end
         end
         ISSUE, WAIT: begin
            if (s_ack || to_hit) begin
               done = 1'b1;
            end else begin
               state_d = WAIT;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (done) begin
         cpl_data = !s_ack ? 32'hDEAD_BEEF : (op_wr_q ? 32'h0 : s_rdata);
         state_d  = RELEASE;
         s_wr_d   = 1'b0;
         s_rd_d   = 1'b0;
         rr_d     = ~grant_q;
         err_d    = ~s_ack;
         if (grant_q) begin
            m1_ack_d   = 1'b1;
            m1_rdata_d = cpl_data;
         end else begin
            m0_ack_d   = 1'b1;
            m0_rdata_d = cpl_data;
         end
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_q       <= 1'b0;
         grant_q    <= 1'b0;
         op_wr_q    <= 1'b0;
         s_addr_q   <= '0;
         s_wdata_q  <= '0;
         s_wr_q     <= 1'b0;
         s_rd_q     <= 1'b0;
         m0_ack_q   <= 1'b0;
         m1_ack_q   <= 1'b0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         grant_q    <= grant_d;
         op_wr_q    <= op_wr_d;
         s_addr_q   <= s_addr_d;
         s_wdata_q  <= s_wdata_d;
         s_wr_q     <= s_wr_d;
         s_rd_q     <= s_rd_d;
         m0_ack_q   <= m0_ack_d;
         m1_ack_q   <= m1_ack_d;
         m0_rdata_q <= m0_rdata_d;
         m1_rdata_q <= m1_rdata_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
      end
   end

   assign m0_ack      = m0_ack_q;
   assign m1_ack      = m1_ack_q;
   assign m0_rdata    = m0_rdata_q;
   assign m1_rdata    = m1_rdata_q;
   assign s_addr      = s_addr_q;
   assign s_wdata     = s_wdata_q;
   assign s_wr        = s_wr_q;
   assign s_rd        = s_rd_q;
   assign grant_id    = grant_q;
   assign busy        = busy_q;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_cfg_bus_arb.sv
// Directed bench for cfg_bus_arb with a transaction-level reference model checked every cycle.
module tb_cfg_bus_arb;

   localparam int TOC = 8;
`ifdef CFG_BUS_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic        m0_wr, m1_wr, m0_rd, m1_rd;
   logic        m0_ack, m1_ack;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] s_addr, s_wdata;
   logic        s_wr, s_rd;
   logic        s_ack;
   logic [31:0] s_rdata;
   logic        grant_id, busy, err_timeout;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int swr_total = 0;
   bit chk_en = 1'b0;

   cfg_bus_arb #(.TIMEOUT_CYCLES(TOC)) dut (
      .clk(clk), .rst(rst),
      .m0_addr(m0_addr), .m1_addr(m1_addr),
      .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
      .m0_wr(m0_wr), .m1_wr(m1_wr), .m0_rd(m0_rd), .m1_rd(m1_rd),
      .m0_ack(m0_ack), .m1_ack(m1_ack),
      .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_wr(s_wr), .s_rd(s_rd),
      .s_ack(s_ack), .s_rdata(s_rdata),
      .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (s_wr === 1'b1) swr_total <= swr_total + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic check1(input string nm, input logic act, input logic exp);
      check(nm, 32'(act), 32'(exp));
   endtask

   // Reference model: a bus is either free, carrying one outstanding request, or in its
   // single cool-down cycle after completion.
   bit          e_swr, e_srd, e_ack0, e_ack1, e_busy, e_grant, e_err;
   logic [31:0] e_addr, e_wdata, e_rd0, e_rd1, e_val;
   bit          prio, who, is_wr, mr0, mr1;
   int          waited;

   initial begin
      e_swr = 0; e_srd = 0; e_ack0 = 0; e_ack1 = 0; e_busy = 0; e_grant = 0; e_err = 0;
      e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0; e_val = '0;
      prio = 0; who = 0; is_wr = 0; mr0 = 0; mr1 = 0; waited = 0;
   end

   always @(posedge clk) begin
      e_ack0 = 1'b0;
      e_ack1 = 1'b0;
      e_err  = 1'b0;
      if (rst) begin
         e_swr = 0; e_srd = 0; e_busy = 0; e_grant = 0; prio = 0; waited = 0;
         e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
      end else if (!e_busy) begin
         mr0 = m0_wr | m0_rd;
         mr1 = m1_wr | m1_rd;
         if (mr0 || mr1) begin
            who     = (mr0 && mr1) ? prio : mr1;
            e_grant = who;
            e_addr  = who ? m1_addr : m0_addr;
            e_wdata = who ? m1_wdata : m0_wdata;
            is_wr   = who ? m1_wr : m0_wr;
            e_swr   = is_wr;
            e_srd   = !is_wr;
            e_busy  = 1'b1;
            waited  = 0;
         end
      end else if (e_swr || e_srd) begin
         if (s_ack || (TO_EN && waited == TOC - 1)) begin
            e_val = !s_ack ? 32'hDEAD_BEEF : (is_wr ? 32'h0 : s_rdata);
            e_err = !s_ack;
            if (who) begin
               e_ack1 = 1'b1;
               e_rd1  = e_val;
            end else begin
               e_ack0 = 1'b1;
               e_rd0  = e_val;
            end
            e_swr = 1'b0;
            e_srd = 1'b0;
            prio  = !who;
         end else begin
            waited++;
         end
      end else begin
         e_busy = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check1("mdl_s_wr", s_wr, e_swr);
         check1("mdl_s_rd", s_rd, e_srd);
         check("mdl_s_addr", s_addr, e_addr);
         check("mdl_s_wdata", s_wdata, e_wdata);
         check1("mdl_m0_ack", m0_ack, e_ack0);
         check1("mdl_m1_ack", m1_ack, e_ack1);
         check("mdl_m0_rdata", m0_rdata, e_rd0);
         check("mdl_m1_rdata", m1_rdata, e_rd1);
         check1("mdl_busy", busy, e_busy);
         check1("mdl_err_timeout", err_timeout, e_err);
         if (e_busy) check1("mdl_grant_id", grant_id, e_grant);
         else        check1("mdl_grant_id_idle", grant_id, 1'b0 | e_grant);
      end
   end

   task automatic clear_inputs();
      m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
      m0_wr = 0; m1_wr = 0; m0_rd = 0; m1_rd = 0;
      s_ack = 0; s_rdata = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_req(output int seen_cyc);
      int n;
      n = 0;
      while (!(s_rd || s_wr) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check1("downstream_req_seen", s_rd | s_wr, 1'b1);
      seen_cyc = cyc;
   endtask

   task automatic serve(input logic [31:0] rdat, input int lat, output int rise_cyc);
      wait_req(rise_cyc);
      repeat (lat) @(negedge clk);
      s_ack   = 1'b1;
      s_rdata = rdat;
      @(negedge clk);
      s_ack   = 1'b0;
      s_rdata = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish actual=running required=done");
      $fatal(1, "watchdog");
   end

   initial begin
      int r, c0, n, sw0;
      int rise [3];
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      check1("rst_busy", busy, 1'b0);
      check1("rst_s_wr", s_wr, 1'b0);
      check("rst_m0_rdata", m0_rdata, 32'h0);
      rst = 1'b0;

      // Single write, downstream ack three cycles after s_wr rises
      @(negedge clk);
      m0_addr = 32'h10; m0_wdata = 32'hA5A5_A5A5; m0_wr = 1'b1;
      sw0 = swr_total;
      serve(32'h0, 3, r);
      check("r030_swr_cycles", 32'(swr_total - sw0), 32'd4);
      check1("r030_m0_ack", m0_ack, 1'b1);
      check("r030_m0_rdata", m0_rdata, 32'h0);
      check("r030_s_addr", s_addr, 32'h10);
      check("r030_s_wdata", s_wdata, 32'hA5A5_A5A5);
      m0_wr = 1'b0;
      @(negedge clk);
      check1("r030_ack_one_pulse", m0_ack, 1'b0);

      // Simultaneous reads alternate between requesters
      do_reset();
      m0_addr = 32'h100; m1_addr = 32'h200; m0_rd = 1'b1; m1_rd = 1'b1;
      serve(32'h11, 1, r);
      check1("r031_first_m0_ack", m0_ack, 1'b1);
      check1("r031_first_m1_quiet", m1_ack, 1'b0);
      check("r031_first_rdata", m0_rdata, 32'h11);
      m0_rd = 1'b0;
      serve(32'h22, 1, r);
      check1("r031_second_m1_ack", m1_ack, 1'b1);
      check("r031_second_rdata", m1_rdata, 32'h22);
      check("r031_m0_rdata_held", m0_rdata, 32'h11);
      m0_rd = 1'b1;
      serve(32'h33, 1, r);
      check1("r031_third_m0_ack", m0_ack, 1'b1);
      check("r031_third_rdata", m0_rdata, 32'h33);
      m0_rd = 1'b0;
      serve(32'h44, 1, r);
      check1("r031_fourth_m1_ack", m1_ack, 1'b1);
      check("r031_fourth_rdata", m1_rdata, 32'h44);
      m1_rd = 1'b0;

      // Back-to-back reads from m1 with a one-cycle downstream responder
      do_reset();
      m1_addr = 32'h300; m1_rd = 1'b1;
      for (int k = 0; k < 3; k++) begin
         serve(32'h40 + 32'(k), 1, rise[k]);
         check1("r032_m1_ack", m1_ack, 1'b1);
         check1("r032_grant_id", grant_id, 1'b1);
         check("r032_m1_rdata", m1_rdata, 32'h40 + 32'(k));
         if (k == 2) m1_rd = 1'b0;
      end
      check("r032_spacing_a", 32'(rise[1] - rise[0]), 32'd4);
      check("r032_spacing_b", 32'(rise[2] - rise[1]), 32'd4);

      // Downstream never acknowledges
      do_reset();
      m0_addr = 32'h400; m0_rd = 1'b1;
      wait_req(c0);
`ifdef CFG_BUS_ARB_TIMEOUT_EN
      n = 0;
      while (!m0_ack && n < 30) begin
         @(negedge clk);
         n++;
      end
      check1("r033_to_ack", m0_ack, 1'b1);
      check("r033_to_latency", 32'(cyc - c0), 32'd8);
      check1("r033_to_err", err_timeout, 1'b1);
      check("r033_to_rdata", m0_rdata, 32'hDEAD_BEEF);
      m0_rd = 1'b0;
      @(negedge clk);
      check1("r033_to_err_pulse", err_timeout, 1'b0);
`else
      n = 0;
      repeat (40) begin
         @(negedge clk);
         check1("r033_busy_hold", busy, 1'b1);
         check1("r033_no_ack", m0_ack, 1'b0);
      end
      s_ack = 1'b1; s_rdata = 32'h66;
      @(negedge clk);
      s_ack = 1'b0; s_rdata = '0;
      check1("r033_late_ack", m0_ack, 1'b1);
      check("r033_late_rdata", m0_rdata, 32'h66);
      check1("r033_no_err", err_timeout, 1'b0);
      m0_rd = 1'b0;
`endif

      // Reset during WAIT, then a stale downstream ack
      do_reset();
      m0_addr = 32'h500; m0_wdata = 32'h1234_5678; m0_wr = 1'b1;
      wait_req(r);
      @(negedge clk);
      check1("r034_in_wait", s_wr, 1'b1);
      rst = 1'b1; m0_wr = 1'b0;
      @(negedge clk);
      rst = 1'b0; s_ack = 1'b1; s_rdata = 32'h99;
      check1("r034_busy_cleared", busy, 1'b0);
      check("r034_s_addr_cleared", s_addr, 32'h0);
      @(negedge clk);
      s_ack = 1'b0; s_rdata = '0;
      check1("r034_no_m0_ack", m0_ack, 1'b0);
      check("r034_m0_rdata", m0_rdata, 32'h0);
      m1_addr = 32'h600; m1_wdata = 32'hCAFE_F00D; m1_wr = 1'b1;
      serve(32'h0, 1, r);
      check1("r034_m1_ack", m1_ack, 1'b1);
      check1("r034_m1_grant", grant_id, 1'b1);
      check("r034_m1_wdata", s_wdata, 32'hCAFE_F00D);
      m1_wr = 1'b0;

      // Spurious ack while idle, then wr+rd together from m0
      do_reset();
      s_ack = 1'b1; s_rdata = 32'h5555;
      @(negedge clk);
      s_ack = 1'b0; s_rdata = '0;
      @(negedge clk);
      check1("r035_spurious_busy", busy, 1'b0);
      check1("r035_spurious_ack", m0_ack, 1'b0);
      check("r035_spurious_rdata", m0_rdata, 32'h0);
      m0_addr = 32'h700; m0_wdata = 32'hBEEF_0001; m0_wr = 1'b1; m0_rd = 1'b1;
      wait_req(r);
      check1("r035_is_write", s_wr, 1'b1);
      check1("r035_no_read", s_rd, 1'b0);
      s_ack = 1'b1; s_rdata = 32'h77;
      @(negedge clk);
      s_ack = 1'b0; s_rdata = '0;
      check1("r035_m0_ack", m0_ack, 1'b1);
      check("r035_write_rdata", m0_rdata, 32'h0);
      m0_wr = 1'b0; m0_rd = 1'b0;

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
